seg_scan_ctrl: RTL

Time-multiplexing scan controller that shares one `SevenSegment` decoder across `NUM_DIGITS` common-anode digits. It cycles through the digits at a fixed refresh rate and inserts a blanking window at the start of every digit slot to suppress ghosting. It drives the decoder's `Dig`/`Ghost` inputs and the active-low digit anodes. It sits between the game/counter logic that produces digit values and the board's display pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 17 +
 rtl/seg_scan_ctrl_counter.sv | 47 ++++
 rtl/seg_scan_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl shared definitions.
// Digit code width, blank code and width helpers.
package seg_scan_ctrl_pkg;

  localparam int DIG_W = 3;
  localparam logic [DIG_W-1:0] DIG_OFF = 3'b111;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_counter.sv
// scan_slot_counter: slot counter and digit index.
// Exposes next-cycle state so the parent can register aligned outputs.
module scan_slot_counter
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int IW = idx_w(NUM_DIGITS),
  localparam int CW = idx_w(REFRESH_DIV)
) (
  input  logic          Clk,
  input  logic          Rst,
  output logic [CW-1:0] cnt_nxt,
  output logic [IW-1:0] idx_nxt,
  output logic          last,
  output logic          frame_nxt
);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          cnt_last;
  logic          idx_last;

  assign cnt_last = (cnt == CW'(REFRESH_DIV - 1));
  assign idx_last = (idx == IW'(NUM_DIGITS - 1));
  assign last     = cnt_last & idx_last;

  always_comb begin
    cnt_nxt = cnt_last ? '0 : cnt + CW'(1);
    idx_nxt = idx;
    if (cnt_last)
      idx_nxt = idx_last ? '0 : idx + IW'(1);
    if (Rst) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end
  end

  assign frame_nxt = (cnt_nxt == CW'(REFRESH_DIV - 1)) &&
                     (idx_nxt == IW'(NUM_DIGITS - 1));

  always_ff @(posedge Clk) begin
    cnt <= cnt_nxt;
    idx <= idx_nxt;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Snapshots digit data per frame and drives Dig/Ghost/An registered.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int IW = idx_w(NUM_DIGITS),
  localparam int CW = idx_w(REFRESH_DIV)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [DIG_W*NUM_DIGITS-1:0] DigVals,
  input  logic [NUM_DIGITS-1:0]       DigEn,
  input  logic                        Blank,
  output logic [DIG_W-1:0]            Dig,
  output logic                        Ghost,
  output logic [NUM_DIGITS-1:0]       An,
  output logic                        Frame
);

  logic [CW-1:0] cnt_nxt;
  logic [IW-1:0] idx_nxt;
  logic          last;
  logic          frame_nxt;

  scan_slot_counter #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_cnt (
    .Clk      (Clk),
    .Rst      (Rst),
    .cnt_nxt  (cnt_nxt),
    .idx_nxt  (idx_nxt),
    .last     (last),
    .frame_nxt(frame_nxt)
  );

  logic [DIG_W*NUM_DIGITS-1:0] snap_vals;
  logic [DIG_W*NUM_DIGITS-1:0] vals_nxt;
  logic [NUM_DIGITS-1:0]       snap_en;
  logic [NUM_DIGITS-1:0]       en_nxt;
  logic                        load;
  phase_e                      phase_nxt;
  logic                        show_nxt;

  // New frame data must be visible in cycle 0 of the frame it belongs to.
  assign load     = Rst | last;
  assign vals_nxt = load ? DigVals : snap_vals;
  assign en_nxt   = load ? DigEn : snap_en;

  if (BLANK_CYCLES == 0) begin : g_noblank
    assign phase_nxt = PH_SHOW;
  end else begin : g_blank
    assign phase_nxt = (cnt_nxt < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
  end

  assign show_nxt = (phase_nxt == PH_SHOW) && en_nxt[idx_nxt] && !Blank;

  always_ff @(posedge Clk) begin
    snap_vals <= vals_nxt;
    snap_en   <= en_nxt;
    if (Rst) begin
      An    <= '1;
      Ghost <= 1'b1;
      Dig   <= '0;
      Frame <= 1'b0;
    end else begin
      Dig   <= vals_nxt[idx_nxt*DIG_W +: DIG_W];
      An    <= show_nxt ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
      Ghost <= !show_nxt;
      Frame <= frame_nxt;
    end
  end

endmodule
